// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: AXI-Lite slave register bank with NUM_REGS 32-bit
// read/write registers, all exported in parallel on regs_o.
// Write path collects AW and W independently into one-deep slots, commits
// one cycle after both are held, then holds B until accepted. Read path is
// independent: one outstanding read, data captured at the AR handshake edge.
// Optional macro AXIL_REGFILE_ALIGN_CHECK_EN: when defined, an AW/AR address
// with addr[1:0] != 0 is treated as out of range (SLVERR).
// Valid/ready: a beat moves on a rising edge where valid & ack are both 1;
// the master keeps valid and payload stable until that edge.
module axi_lite_regfile #(
    parameter int unsigned NUM_REGS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     _slv_ep_aw_req_valid,
    input  logic [34:0]              _slv_ep_aw_req_0,
    output logic                     _slv_ep_aw_req_ack,
    input  logic                     _slv_ep_w_req_valid,
    input  logic [35:0]              _slv_ep_w_req_0,
    output logic                     _slv_ep_w_req_ack,
    output logic                     _slv_ep_b_resp_valid,
    output logic [1:0]               _slv_ep_b_resp_0,
    input  logic                     _slv_ep_b_resp_ack,
    input  logic                     _slv_ep_ar_req_valid,
    input  logic [34:0]              _slv_ep_ar_req_0,
    output logic                     _slv_ep_ar_req_ack,
    output logic                     _slv_ep_r_resp_valid,
    output logic [33:0]              _slv_ep_r_resp_0,
    input  logic                     _slv_ep_r_resp_ack,
    output logic [NUM_REGS*32-1:0]   regs_o
);

    localparam int unsigned IW   = $clog2(NUM_REGS);
    localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

    wr_state_e      wr_state_q, wr_state_d;
    rd_state_e      rd_state_q, rd_state_d;
    logic           live_q;
    logic           aw_full_q, w_full_q;
    logic [31:0]    aw_addr_q;
    logic [31:0]    w_data_q;
    logic [3:0]     w_strb_q;
    logic [1:0]     b_resp_q;
    logic [31:0]    r_data_q;
    logic [1:0]     r_resp_q;
    logic           commit;
    logic           aw_ack, w_ack, ar_ack;
    logic [31:0]    ar_addr;
    logic [31:0]    regs_q [NUM_REGS];
    logic           unused_prot;

    // prot is carried in the payload but has no effect on this bank
    assign unused_prot = ^{_slv_ep_aw_req_0[2:0], _slv_ep_ar_req_0[2:0]};
    assign ar_addr     = _slv_ep_ar_req_0[34:3];

    function automatic logic addr_ok(input logic [31:0] addr);
        logic [31:0] off;
        off     = addr - BASE_ADDR;
        addr_ok = (off < SPAN);
`ifdef AXIL_REGFILE_ALIGN_CHECK_EN
        if (addr[1:0] != 2'b00) addr_ok = 1'b0;
`endif
    endfunction

    function automatic logic [IW-1:0] addr_idx(input logic [31:0] addr);
        logic [31:0] off;
        off      = (addr - BASE_ADDR) >> 2;
        addr_idx = IW'(off);
    endfunction

    // live_q keeps every ack low throughout reset and raises it one cycle after release
    always_ff @(posedge clk_i) begin
        if (rst_i) live_q <= 1'b0;
        else       live_q <= 1'b1;
    end

    // FSM state registers for both paths
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
        end
    end

    // Write FSM: slot acks while idle, commit once both slots hold a beat
    always_comb begin
        wr_state_d = wr_state_q;
        aw_ack     = 1'b0;
        w_ack      = 1'b0;
        commit     = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                aw_ack = live_q & ~aw_full_q;
                w_ack  = live_q & ~w_full_q;
                if (aw_full_q && w_full_q) begin
                    commit     = 1'b1;
                    wr_state_d = WR_RESP;
                end
            end
            WR_RESP: if (_slv_ep_b_resp_ack) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Read FSM: accept AR while idle, hold R until accepted
    always_comb begin
        rd_state_d = rd_state_q;
        ar_ack     = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                ar_ack = live_q;
                if (_slv_ep_ar_req_valid && live_q) rd_state_d = RD_RESP;
            end
            RD_RESP: if (_slv_ep_r_resp_ack) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // AW/W holding slots and the B response code
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_resp_q  <= '0;
        end else begin
            if (_slv_ep_aw_req_valid && aw_ack) begin
                aw_full_q <= 1'b1;
                aw_addr_q <= _slv_ep_aw_req_0[34:3];
            end
            if (_slv_ep_w_req_valid && w_ack) begin
                w_full_q <= 1'b1;
                w_data_q <= _slv_ep_w_req_0[35:4];
                w_strb_q <= _slv_ep_w_req_0[3:0];
            end
            if (commit) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
                b_resp_q  <= addr_ok(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Register array: byte-strobed commit, out-of-range writes dropped
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (commit && addr_ok(aw_addr_q)) begin
            for (int k = 0; k < 4; k++) begin
                if (w_strb_q[k]) regs_q[addr_idx(aw_addr_q)][8*k +: 8] <= w_data_q[8*k +: 8];
            end
        end
    end

    // R payload capture: pre-commit value, since regs_q updates on the same edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data_q <= '0;
            r_resp_q <= '0;
        end else if (_slv_ep_ar_req_valid && ar_ack) begin
            if (addr_ok(ar_addr)) begin
                r_data_q <= regs_q[addr_idx(ar_addr)];
                r_resp_q <= RESP_OKAY;
            end else begin
                r_data_q <= '0;
                r_resp_q <= RESP_SLVERR;
            end
        end
    end

    // Parallel export of every register
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_o[32*i +: 32] = regs_q[i];
    end

    assign _slv_ep_aw_req_ack   = aw_ack;
    assign _slv_ep_w_req_ack    = w_ack;
    assign _slv_ep_ar_req_ack   = ar_ack;
    assign _slv_ep_b_resp_valid = (wr_state_q == WR_RESP);
    assign _slv_ep_b_resp_0     = b_resp_q;
    assign _slv_ep_r_resp_valid = (rd_state_q == RD_RESP);
    assign _slv_ep_r_resp_0     = {r_data_q, r_resp_q};

endmodule
